led_mux_scan: RTL and testbench

Parametrised time-multiplexed 7-segment/LED scanner for the synth front-panel display. Drives DIGITS common-cathode digits from one shared segment bus, using a one-hot digit select rotated by an internal clock divider. Adds what the fixed 4-phase ground rotator lacks:
- BCD-to-segment decode;
- tear-free frame-aligned value loading;
- leading-zero blanking;
- optional PWM brightness.

Sits between the register/SPI-receive logic and the LED pins.

---
 rtl/led_mux_scan_if.sv | 33 +++
 rtl/led_mux_scan.sv | 169 ++++++++++++++++
 tb/tb_led_mux_scan.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/led_mux_scan_if.sv
`default_nettype none
// ============================================================================
// Module      : led_mux_scan_if
// Description : Bundle between the register/SPI-receive side (master) and
//               the LED scanner (slave).
//               master drives : bcd_in, dp_in, load, lz_en, bright
//               slave drives  : seg_out, dp_out, dig_sel, frame_tick
// Revision    : 1.0 - initial release
// ============================================================================
interface led_mux_scan_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] bcd_in;      // digit 0 at [3:0]
    logic [DIGITS-1:0]   dp_in;       // decimal point per digit
    logic                load;        // single-cycle capture strobe
    logic                lz_en;       // leading-zero blanking enable
    logic [2:0]          bright;      // brightness, 7 = full
    logic [6:0]          seg_out;     // {g,f,e,d,c,b,a}, active-high
    logic                dp_out;      // decimal point of active digit
    logic [DIGITS-1:0]   dig_sel;     // one-hot digit enable
    logic                frame_tick;  // pulse at each frame start

    modport master (
        output bcd_in, dp_in, load, lz_en, bright,
        input  seg_out, dp_out, dig_sel, frame_tick
    );

    modport slave (
        input  bcd_in, dp_in, load, lz_en, bright,
        output seg_out, dp_out, dig_sel, frame_tick
    );
endinterface
`default_nettype wire

// File: rtl/led_mux_scan.sv
`default_nettype none
// ============================================================================
// Module      : led_mux_scan
// Description : Time-multiplexed 7-segment scanner. A free-running divider
//               sets the slot length (2^DIV_W clk), a scan index rotates a
//               one-hot digit select, values are loaded tear-free at frame
//               boundaries, BCD is decoded with optional leading-zero
//               blanking. Optional PWM dimming when LED_MUX_DIM_EN is
//               defined (otherwise bus.bright is unused).
// Ports       : clk  - system clock
//               res  - asynchronous active-high reset
//               bus  - led_mux_scan_if.slave (inputs bcd_in, dp_in, load,
//                      lz_en, bright; registered outputs seg_out, dp_out,
//                      dig_sel, frame_tick)
// Revision    : 1.0 - initial release
// ============================================================================
module led_mux_scan #(
    parameter int DIGITS = 4,   // 2..8
    parameter int DIV_W  = 5    // >= 3
) (
    input  wire logic          clk,
    input  wire logic          res,
    led_mux_scan_if.slave      bus
);

    localparam int                IDX_W      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0]  C_LAST_IDX = IDX_W'(DIGITS - 1);

    logic [DIV_W-1:0]       r_div_cnt;
    logic [IDX_W-1:0]       r_dig_idx;
    logic                   r_run;
    logic                   r_pending;
    logic                   r_frame_d;
    logic [DIGITS-1:0][3:0] r_shadow_bcd;
    logic [DIGITS-1:0]      r_shadow_dp;
    logic [DIGITS-1:0][3:0] r_disp_bcd;
    logic [DIGITS-1:0]      r_disp_dp;
    logic [6:0]             r_seg;
    logic                   r_dp;
    logic [DIGITS-1:0]      r_dig_sel;
    logic                   r_frame_tick;

    logic                   w_slot_tick;
    logic                   w_frame;
    logic                   w_enable;
    logic                   w_zero_run;
    logic [DIGITS-1:0]      w_blank;
    logic [3:0]             w_cur_bcd;
    logic [6:0]             w_seg;

    function automatic logic [6:0] f_decode(input logic [3:0] v);
        case (v)
            4'd0:    f_decode = 7'h3F;
            4'd1:    f_decode = 7'h06;
            4'd2:    f_decode = 7'h5B;
            4'd3:    f_decode = 7'h4F;
            4'd4:    f_decode = 7'h66;
            4'd5:    f_decode = 7'h6D;
            4'd6:    f_decode = 7'h7D;
            4'd7:    f_decode = 7'h07;
            4'd8:    f_decode = 7'h7F;
            4'd9:    f_decode = 7'h6F;
            default: f_decode = 7'h00;
        endcase
    endfunction

    assign w_slot_tick = &r_div_cnt;
    // Only a running scanner can reach the last index, so no run term needed.
    assign w_frame     = w_slot_tick && (r_dig_idx == C_LAST_IDX);

    // Divider, scan index and run flag. The first slot_tick after reset only
    // starts the scan, so digit 0 is the first one driven.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_div_cnt <= '0;
            r_dig_idx <= '0;
            r_run     <= 1'b0;
            r_frame_d <= 1'b0;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
            r_frame_d <= w_frame;
            if (w_slot_tick) begin
                if (!r_run) begin
                    r_run <= 1'b1;
                end else if (r_dig_idx == C_LAST_IDX) begin
                    r_dig_idx <= '0;
                end else begin
                    r_dig_idx <= r_dig_idx + 1'b1;
                end
            end
        end
    end

    // Shadow / display pair. On a boundary coincident with load the display
    // takes the old shadow (RHS sampled before update) and pending stays set.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_shadow_bcd <= '0;
            r_shadow_dp  <= '0;
            r_disp_bcd   <= '0;
            r_disp_dp    <= '0;
            r_pending    <= 1'b0;
        end else begin
            if (bus.load) begin
                r_shadow_bcd <= bus.bcd_in;
                r_shadow_dp  <= bus.dp_in;
                r_pending    <= 1'b1;
            end else if (w_frame) begin
                r_pending    <= 1'b0;
            end
            if (w_frame && r_pending) begin
                r_disp_bcd <= r_shadow_bcd;
                r_disp_dp  <= r_shadow_dp;
            end
        end
    end

    // Leading-zero blanking: walk from the most significant digit down and
    // keep blanking while every digit seen so far is zero. Digit 0 is exempt.
    always_comb begin
        w_blank    = '0;
        w_zero_run = bus.lz_en;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            w_zero_run = w_zero_run && (r_disp_bcd[i] == 4'd0);
            w_blank[i] = w_zero_run;
        end
    end

    assign w_cur_bcd = r_disp_bcd[r_dig_idx];
    assign w_seg     = w_blank[r_dig_idx] ? 7'h00 : f_decode(w_cur_bcd);

`ifdef LED_MUX_DIM_EN
    // Top three divider bits split each slot into eighths; on for bright+1.
    assign w_enable = (r_div_cnt[DIV_W-1 -: 3] <= bus.bright);
`else
    logic w_unused_bright;
    assign w_enable        = 1'b1;
    assign w_unused_bright = ^bus.bright;
`endif

    // Output register: one cycle behind the scan index.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_seg        <= '0;
            r_dp         <= 1'b0;
            r_dig_sel    <= '0;
            r_frame_tick <= 1'b0;
        end else begin
            // Delayed once more so the pulse lines up with digit 0 appearing.
            r_frame_tick <= r_frame_d;
            if (r_run && w_enable) begin
                r_dig_sel <= DIGITS'(1) << r_dig_idx;
                r_seg     <= w_seg;
                r_dp      <= r_disp_dp[r_dig_idx];
            end else begin
                r_dig_sel <= '0;
                r_seg     <= '0;
                r_dp      <= 1'b0;
            end
        end
    end

    assign bus.seg_out    = r_seg;
    assign bus.dp_out     = r_dp;
    assign bus.dig_sel    = r_dig_sel;
    assign bus.frame_tick = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_led_mux_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_mux_scan
// Description : Directed self-checking bench for led_mux_scan (DIGITS=4,
//               DIV_W=5). Edge counter t counts rising edges since reset
//               release; outputs are sampled 1 time unit after an edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_mux_scan;

    logic clk = 1'b0;
    logic res = 1'b1;
    int   t = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cnt;

    led_mux_scan_if #(.DIGITS(4)) u_if ();

    led_mux_scan #(
        .DIGITS (4),
        .DIV_W  (5)
    ) u_dut (
        .clk (clk),
        .res (res),
        .bus (u_if.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0d)", tag, got, exp, t);
        end
    endtask

    task automatic go_to(input int k);
        while (t < k) begin
            @(posedge clk);
            #1;
            t++;
        end
    endtask

    task automatic show(input string tag, input logic [3:0] sel, input logic [6:0] seg);
        chk({tag, "_sel"}, 32'(u_if.dig_sel), 32'(sel));
        chk({tag, "_seg"}, 32'(u_if.seg_out), 32'(seg));
    endtask

    initial begin
        u_if.bcd_in = '0;
        u_if.dp_in  = '0;
        u_if.load   = 1'b0;
        u_if.lz_en  = 1'b0;
        u_if.bright = 3'd7;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        show("rst", 4'b0000, 7'h00);
        chk("rst_dp", 32'(u_if.dp_out), 32'd0);
        chk("rst_ft", 32'(u_if.frame_tick), 32'd0);

        @(negedge clk);
        res = 1'b0;
        t   = 0;

        // 1: start-up scan sequence
        go_to(32);  show("s1_idle", 4'b0000, 7'h00);
        go_to(33);  show("s1_d0", 4'b0001, 7'h3F);
        chk("s1_ft0", 32'(u_if.frame_tick), 32'd0);
        go_to(65);  show("s1_d1", 4'b0010, 7'h3F);
        go_to(97);  show("s1_d2", 4'b0100, 7'h3F);
        go_to(129); show("s1_d3", 4'b1000, 7'h3F);
        go_to(160); chk("s1_ft_pre", 32'(u_if.frame_tick), 32'd0);
        chk("s1_sel_pre", 32'(u_if.dig_sel), 32'h8);
        go_to(161); chk("s1_ft", 32'(u_if.frame_tick), 32'd1);
        chk("s1_wrap", 32'(u_if.dig_sel), 32'h1);
        go_to(162); chk("s1_ft_end", 32'(u_if.frame_tick), 32'd0);

        // 2: mid-frame load held until boundary
        go_to(170);
        u_if.bcd_in = 16'h1234;
        u_if.load   = 1'b1;
        go_to(171);
        u_if.load   = 1'b0;
        go_to(193); show("s2_old_d1", 4'b0010, 7'h3F);
        go_to(288); show("s2_old_d3", 4'b1000, 7'h3F);
        go_to(289); show("s2_d0", 4'b0001, 7'h66);
        chk("s2_ft", 32'(u_if.frame_tick), 32'd1);
        go_to(321); show("s2_d1", 4'b0010, 7'h4F);
        go_to(353); show("s2_d2", 4'b0100, 7'h5B);
        go_to(385); show("s2_d3", 4'b1000, 7'h06);

        // 3: leading-zero blanking, dp on blanked digit
        go_to(390);
        u_if.bcd_in = 16'h0070;
        u_if.dp_in  = 4'b0100;
        u_if.lz_en  = 1'b1;
        u_if.load   = 1'b1;
        go_to(391);
        u_if.load   = 1'b0;
        go_to(417); show("s3_d0", 4'b0001, 7'h3F);
        go_to(449); show("s3_d1", 4'b0010, 7'h07);
        go_to(481); show("s3_d2", 4'b0100, 7'h00);
        chk("s3_dp2", 32'(u_if.dp_out), 32'd1);
        go_to(513); show("s3_d3", 4'b1000, 7'h00);
        chk("s3_dp3", 32'(u_if.dp_out), 32'd0);
        go_to(520);
        u_if.lz_en = 1'b0;
        go_to(521); show("s3_nolz_d3", 4'b1000, 7'h3F);
        go_to(609); show("s3_nolz_d2", 4'b0100, 7'h3F);
        chk("s3_nolz_dp2", 32'(u_if.dp_out), 32'd1);

        // 4: load coincident with boundary; A..F decode blank
        go_to(620);
        u_if.lz_en = 1'b1;
        u_if.dp_in = 4'b0000;
        go_to(650);
        u_if.bcd_in = 16'h0005;
        u_if.load   = 1'b1;
        go_to(651);
        u_if.load   = 1'b0;
        go_to(671);
        u_if.bcd_in = 16'hA00F;
        u_if.load   = 1'b1;
        go_to(672);
        u_if.load   = 1'b0;
        go_to(673); show("s4_old_d0", 4'b0001, 7'h6D);
        go_to(705); show("s4_old_d1", 4'b0010, 7'h00);
        go_to(800); show("s4_old_d3", 4'b1000, 7'h00);
        go_to(801); show("s4_d0", 4'b0001, 7'h00);
        chk("s4_ft", 32'(u_if.frame_tick), 32'd1);
        go_to(833); show("s4_d1", 4'b0010, 7'h3F);
        go_to(865); show("s4_d2", 4'b0100, 7'h3F);
        go_to(897); show("s4_d3", 4'b1000, 7'h00);

        // 5: asynchronous reset mid-frame
        go_to(1000);
        chk("s5_pre", 32'(u_if.dig_sel), 32'h4);
        res = 1'b1;
        #1;
        show("s5_async", 4'b0000, 7'h00);
        chk("s5_dp", 32'(u_if.dp_out), 32'd0);
        repeat (2) @(negedge clk);
        res = 1'b0;
        t   = 0;
        go_to(32);  show("s5_idle", 4'b0000, 7'h00);
        go_to(33);  show("s5_d0", 4'b0001, 7'h3F);
        go_to(65);  show("s5_d1", 4'b0010, 7'h00);
        go_to(160); chk("s5_ft_pre", 32'(u_if.frame_tick), 32'd0);
        go_to(161); chk("s5_ft", 32'(u_if.frame_tick), 32'd1);
        chk("s5_wrap", 32'(u_if.dig_sel), 32'h1);

`ifdef LED_MUX_DIM_EN
        // 6: PWM duty per slot
        go_to(192);
        u_if.bright = 3'd3;
        cnt = 0;
        for (int k = 193; k <= 224; k++) begin
            go_to(k);
            if (u_if.dig_sel != 4'b0000) cnt++;
        end
        chk("s6_b3", 32'(cnt), 32'd16);
        u_if.bright = 3'd0;
        cnt = 0;
        for (int k = 225; k <= 256; k++) begin
            go_to(k);
            if (u_if.dig_sel != 4'b0000) cnt++;
        end
        chk("s6_b0", 32'(cnt), 32'd4);
        u_if.bright = 3'd7;
        cnt = 0;
        for (int k = 257; k <= 288; k++) begin
            go_to(k);
            if (u_if.dig_sel != 4'b0000) cnt++;
        end
        chk("s6_b7", 32'(cnt), 32'd32);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
